// File: rtl/timer_multi_if.sv
// RIB request/response bus (valid-ready) between the core fabric and the
// timer_multi peripheral. Signal names keep the slave-side direction suffixes.
interface timer_multi_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] data_o;

  modport slave (
    input  addr_i, data_i, sel_i, we_i, req_valid_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, data_o
  );

  modport master (
    output addr_i, data_i, sel_i, we_i, req_valid_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, data_o
  );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel up-counting timer with a shared prescaler, periodic/one-shot
// channels and a combined maskable interrupt, exposed as a RIB slave.
module timer_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  timer_multi_if.slave  bus,
  output logic          int_sig_o
);

  localparam logic [7:0] ADDR_PRESC    = 8'h00;
  localparam logic [7:0] ADDR_INT_STAT = 8'h04;
  localparam logic [7:0] ADDR_INT_EN   = 8'h08;

  // Channel n occupies 0x10 + 0x10*n; r selects CTRL (0), LOAD (1), COUNT (2).
  function automatic logic [7:0] ch_addr(input int n, input int r);
    return 8'(16 * (n + 1) + 4 * r);
  endfunction

  logic [15:0]       presc_q, presc_d;
  logic [15:0]       presc_cnt_q, presc_cnt_d;
  logic [NUM_CH-1:0] int_stat_q, int_stat_d;
  logic [NUM_CH-1:0] int_en_q, int_en_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d;
  logic [NUM_CH-1:0] ch_os_q, ch_os_d;
  logic [CNT_W-1:0]  load_q  [NUM_CH];
  logic [CNT_W-1:0]  load_d  [NUM_CH];
  logic [CNT_W-1:0]  count_q [NUM_CH];
  logic [CNT_W-1:0]  count_d [NUM_CH];
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        accept;
  logic        wr;
  logic        tick;
  logic [7:0]  word_addr;
  logic [31:0] wmask;
  logic        unused_addr_bits;

  assign accept    = bus.req_valid_i & ~rsp_valid_q;
  assign wr        = accept & bus.we_i;
  assign word_addr = {bus.addr_i[7:2], 2'b00};
  assign wmask     = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}},
                      {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};
  assign tick      = (presc_cnt_q == presc_q);

  assign bus.req_ready_o = ~rsp_valid_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.data_o      = rdata_q;
  assign int_sig_o       = |(int_stat_q & int_en_q);
  assign unused_addr_bits = ^{bus.addr_i[31:8], bus.addr_i[1:0]};

  // Global registers and prescaler; CTRL, INT_EN and INT_STAT live in byte 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    presc_d     = presc_q;
    presc_cnt_d = tick ? 16'd0 : presc_cnt_q + 16'd1;
    int_en_d    = int_en_q;
    if (wr && word_addr == ADDR_PRESC)
      presc_d = 16'((32'(presc_q) & ~wmask) | (bus.data_i & wmask));
    if (wr && word_addr == ADDR_INT_EN && bus.sel_i[0])
      int_en_d = bus.data_i[NUM_CH-1:0];
  end

  always_comb begin
    int_stat_d = int_stat_q;
    if (wr && word_addr == ADDR_INT_STAT && bus.sel_i[0])
      int_stat_d = int_stat_q & ~bus.data_i[NUM_CH-1:0];
    for (int n = 0; n < NUM_CH; n++) begin
      ch_en_d[n] = ch_en_q[n];
      ch_os_d[n] = ch_os_q[n];
      load_d[n]  = load_q[n];
      count_d[n] = count_q[n];
      // Expiry is applied after the W1C above (set wins) and before the CTRL write (write wins).
      if (tick && ch_en_q[n]) begin
        if (count_q[n] >= load_q[n]) begin
          count_d[n]    = '0;
          int_stat_d[n] = 1'b1;
          if (ch_os_q[n]) ch_en_d[n] = 1'b0;
        end else begin
          count_d[n] = count_q[n] + CNT_W'(1);
        end
      end
      if (wr && word_addr == ch_addr(n, 0) && bus.sel_i[0]) begin
        ch_en_d[n] = bus.data_i[0];
        ch_os_d[n] = bus.data_i[1];
        if (!ch_en_q[n] && bus.data_i[0]) count_d[n] = '0;
      end
      if (wr && word_addr == ch_addr(n, 1))
        load_d[n] = CNT_W'((32'(load_q[n]) & ~wmask) | (bus.data_i & wmask));
    end
  end

  // Read data is sampled from the pre-edge register values at the accept edge.
  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = '0;
      if (!bus.we_i) begin
        if (word_addr == ADDR_PRESC)    rdata_d = 32'(presc_q);
        if (word_addr == ADDR_INT_STAT) rdata_d = 32'(int_stat_q);
        if (word_addr == ADDR_INT_EN)   rdata_d = 32'(int_en_q);
        for (int n = 0; n < NUM_CH; n++) begin
          if (word_addr == ch_addr(n, 0)) rdata_d = {30'd0, ch_os_q[n], ch_en_q[n]};
          if (word_addr == ch_addr(n, 1)) rdata_d = 32'(load_q[n]);
          if (word_addr == ch_addr(n, 2)) rdata_d = 32'(count_q[n]);
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (accept)                          rsp_valid_d = 1'b1;
    else if (rsp_valid_q && bus.rsp_ready_i) rsp_valid_d = 1'b0;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
      int_stat_q  <= '0;
      int_en_q    <= '0;
      ch_en_q     <= '0;
      ch_os_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      // NOTE: the per-channel arrays are software-visible registers, so they are reset too.
      for (int n = 0; n < NUM_CH; n++) begin
        load_q[n]  <= '0;
        count_q[n] <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      int_stat_q  <= int_stat_d;
      int_en_q    <= int_en_d;
      ch_en_q     <= ch_en_d;
      ch_os_q     <= ch_os_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      for (int n = 0; n < NUM_CH; n++) begin
        load_q[n]  <= load_d[n];
        count_q[n] <= count_d[n];
      end
    end
  end

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: a 4-channel/32-bit instance plus a
// 2-channel/16-bit instance sharing clock and reset.
module tb_timer_multi;

  logic clk;
  logic rst;
  logic int_a;
  logic int_b;
  int   n_cmp;
  int   n_err;

  timer_multi_if bus_a ();
  timer_multi_if bus_b ();

  timer_multi #(.NUM_CH(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .int_sig_o(int_a)
  );

  timer_multi #(.NUM_CH(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .int_sig_o(int_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  // One complete transaction: accept on the first posedge, complete on the next.
  task automatic xfer(input bit to_b, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel,
                      output logic [31:0] rdata);
    int   waited;
    logic ready;
    logic valid;
    @(negedge clk);
    bus_a.addr_i = addr;  bus_b.addr_i = addr;
    bus_a.data_i = wdata; bus_b.data_i = wdata;
    bus_a.sel_i  = sel;   bus_b.sel_i  = sel;
    bus_a.we_i   = we;    bus_b.we_i   = we;
    bus_a.req_valid_i = !to_b;
    bus_b.req_valid_i = to_b;
    waited = 0;
    ready  = to_b ? bus_b.req_ready_o : bus_a.req_ready_o;
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
      ready = to_b ? bus_b.req_ready_o : bus_a.req_ready_o;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL xfer_ready addr=%h: req_ready_o=%b, expected 1 within 20 cycles", addr, ready);
      bus_a.req_valid_i = 1'b0;
      bus_b.req_valid_i = 1'b0;
      rdata = '0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid_i = 1'b0;
    bus_b.req_valid_i = 1'b0;
    valid = to_b ? bus_b.rsp_valid_o : bus_a.rsp_valid_o;
    rdata = to_b ? bus_b.data_o : bus_a.data_o;
    n_cmp++;
    if (valid !== 1'b1) begin
      n_err++;
      $display("FAIL xfer_rsp addr=%h: rsp_valid_o=%b, expected 1 after accept", addr, valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    xfer(1'b0, 1'b1, addr, wdata, 4'hF, d);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] rdata);
    xfer(1'b0, 1'b0, addr, 32'd0, 4'hF, rdata);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [7:0]  addrs [15];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24, 8'h28,
              8'h30, 8'h34, 8'h38, 8'h40, 8'h44, 8'h48};
    do_reset();
    n_cmp++; if (bus_a.req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b, expected 1", bus_a.req_ready_o); end
    n_cmp++; if (bus_a.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b, expected 0", bus_a.rsp_valid_o); end
    n_cmp++; if (bus_a.data_o !== 32'd0) begin n_err++; $display("FAIL reset_data_o: got %h, expected 0", bus_a.data_o); end
    n_cmp++; if (int_a !== 1'b0) begin n_err++; $display("FAIL reset_int: got %b, expected 0", int_a); end
    foreach (addrs[i]) begin
      rd({24'd0, addrs[i]}, d);
      n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_reg addr=%h: got %h, expected 0", addrs[i], d); end
    end
    rd(32'hFC, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL unmapped_read: got %h, expected 0", d); end
  endtask

  // PRESC=0: expiries every 4 edges starting 4 edges after the CTRL accept edge E.
  task automatic test_periodic;
    logic [31:0] d;
    logic        exp;
    do_reset();
    wr(32'h14, 32'd3);
    wr(32'h08, 32'd1);
    wr(32'h10, 32'd1);
    n_cmp++; if (int_a !== 1'b0) begin n_err++; $display("FAIL periodic_int E+1: got %b, expected 0", int_a); end
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      exp = (k == 4);
      n_cmp++; if (int_a !== exp) begin n_err++; $display("FAIL periodic_int E+%0d: got %b, expected %b", k, int_a, exp); end
    end
    wr(32'h04, 32'd1);
    n_cmp++; if (int_a !== 1'b0) begin n_err++; $display("FAIL periodic_w1c E+6: got %b, expected 0", int_a); end
    for (int k = 7; k <= 8; k++) begin
      @(posedge clk); #1;
      exp = (k == 8);
      n_cmp++; if (int_a !== exp) begin n_err++; $display("FAIL periodic_int E+%0d: got %b, expected %b", k, int_a, exp); end
    end
    rd(32'h04, d);
    n_cmp++; if (d !== 32'd1) begin n_err++; $display("FAIL periodic_stat: got %h, expected 1", d); end
  endtask

  // PRESC=2 written at edge P gives ticks at P+3k; CTRL accepted at E=P+6, expiry at E+6.
  task automatic test_oneshot;
    logic [31:0] d;
    logic        exp;
    do_reset();
    wr(32'h00, 32'd2);
    wr(32'h24, 32'd1);
    wr(32'h08, 32'd2);
    wr(32'h20, 32'd3);
    n_cmp++; if (int_a !== 1'b0) begin n_err++; $display("FAIL oneshot_int E+1: got %b, expected 0", int_a); end
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      exp = (k == 6);
      n_cmp++; if (int_a !== exp) begin n_err++; $display("FAIL oneshot_int E+%0d: got %b, expected %b", k, int_a, exp); end
    end
    rd(32'h20, d);
    n_cmp++; if (d !== 32'd2) begin n_err++; $display("FAIL oneshot_ctrl: got %h, expected 2", d); end
    rd(32'h28, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL oneshot_count: got %h, expected 0", d); end
    repeat (10) @(posedge clk);
    rd(32'h28, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL oneshot_frozen: got %h, expected 0", d); end
    rd(32'h04, d);
    n_cmp++; if (d !== 32'd2) begin n_err++; $display("FAIL oneshot_stat: got %h, expected 2", d); end
  endtask

  // Ch2, PRESC=0, CTRL accepted at E. LOAD drops to 5 at E+10 (COUNT=10), expiry at E+11, E+17.
  task automatic test_load_lower;
    logic [31:0] d;
    do_reset();
    wr(32'h08, 32'd4);
    wr(32'h34, 32'd100);
    wr(32'h30, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (int_a !== 1'b0) begin n_err++; $display("FAIL lower_pre E+9: got %b, expected 0", int_a); end
    wr(32'h34, 32'd5);
    n_cmp++; if (int_a !== 1'b1) begin n_err++; $display("FAIL lower_expiry E+11: got %b, expected 1", int_a); end
    wr(32'h04, 32'd4);
    n_cmp++; if (int_a !== 1'b0) begin n_err++; $display("FAIL lower_w1c E+13: got %b, expected 0", int_a); end
    repeat (3) @(posedge clk);
    wr(32'h04, 32'd4);
    n_cmp++; if (int_a !== 1'b1) begin n_err++; $display("FAIL set_wins E+18: got %b, expected 1", int_a); end
    rd(32'h04, d);
    n_cmp++; if (d !== 32'd4) begin n_err++; $display("FAIL set_wins_stat: got %h, expected 4", d); end
    rd(32'h38, d);
    n_cmp++; if (d !== 32'd3) begin n_err++; $display("FAIL count_pretick: got %h, expected 3", d); end
  endtask

  task automatic test_byte_enables;
    logic [31:0] d;
    do_reset();
    xfer(1'b0, 1'b1, 32'h14, 32'h12345678, 4'b0010, d);
    rd(32'h14, d);
    n_cmp++; if (d !== 32'h00005600) begin n_err++; $display("FAIL load_sel: got %h, expected 00005600", d); end
    xfer(1'b0, 1'b1, 32'h00, 32'h0000ABCD, 4'b0001, d);
    rd(32'h00, d);
    n_cmp++; if (d !== 32'h000000CD) begin n_err++; $display("FAIL presc_sel: got %h, expected 000000cd", d); end
    xfer(1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL b_write_data: got %h, expected 0", d); end
    xfer(1'b1, 1'b0, 32'h30, 32'd0, 4'hF, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL b_absent_ch: got %h, expected 0", d); end
    xfer(1'b1, 1'b1, 32'h24, 32'h00012345, 4'hF, d);
    xfer(1'b1, 1'b0, 32'h24, 32'd0, 4'hF, d);
    n_cmp++; if (d !== 32'h00002345) begin n_err++; $display("FAIL b_load_width: got %h, expected 00002345", d); end
  endtask

  task automatic test_back_to_back;
    int accepts;
    accepts = 0;
    do_reset();
    @(negedge clk);
    bus_a.addr_i = 32'h00; bus_a.we_i = 1'b0; bus_a.sel_i = 4'hF;
    bus_a.rsp_ready_i = 1'b1;
    bus_a.req_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.req_ready_o && bus_a.req_valid_i) accepts++;
      @(negedge clk);
    end
    bus_a.req_valid_i = 1'b0;
    n_cmp++; if (accepts !== 5) begin n_err++; $display("FAIL back_to_back: got %0d accepts, expected 5 in 10 cycles", accepts); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_hold_reset;
    logic [31:0] d;
    do_reset();
    wr(32'h00, 32'h1234);
    wr(32'h14, 32'h55);
    @(negedge clk);
    bus_a.addr_i = 32'h00; bus_a.we_i = 1'b0;
    bus_a.rsp_ready_i = 1'b0;
    bus_a.req_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_a.req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus_a.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_valid cyc=%0d: got %b, expected 1", i, bus_a.rsp_valid_o); end
      n_cmp++; if (bus_a.data_o !== 32'h1234) begin n_err++; $display("FAIL hold_data cyc=%0d: got %h, expected 00001234", i, bus_a.data_o); end
      n_cmp++; if (bus_a.req_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_ready cyc=%0d: got %b, expected 0", i, bus_a.req_ready_o); end
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus_a.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL hold_rst_valid: got %b, expected 0", bus_a.rsp_valid_o); end
    n_cmp++; if (bus_a.req_ready_o !== 1'b1) begin n_err++; $display("FAIL hold_rst_ready: got %b, expected 1", bus_a.req_ready_o); end
    n_cmp++; if (bus_a.data_o !== 32'd0) begin n_err++; $display("FAIL hold_rst_data: got %h, expected 0", bus_a.data_o); end
    @(negedge clk);
    rst = 1'b0;
    bus_a.rsp_ready_i = 1'b1;
    rd(32'h00, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL hold_rst_presc: got %h, expected 0", d); end
    rd(32'h14, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL hold_rst_load: got %h, expected 0", d); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_a.addr_i = '0; bus_a.data_i = '0; bus_a.sel_i = '0; bus_a.we_i = 1'b0;
    bus_a.req_valid_i = 1'b0; bus_a.rsp_ready_i = 1'b1;
    bus_b.addr_i = '0; bus_b.data_i = '0; bus_b.sel_i = '0; bus_b.we_i = 1'b0;
    bus_b.req_valid_i = 1'b0; bus_b.rsp_ready_i = 1'b1;
    test_reset();
    test_periodic();
    test_oneshot();
    test_load_lower();
    test_byte_enables();
    test_back_to_back();
    test_hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
